mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader.sv | 151 +++++++++++++++
 tb/tb_mem_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - byte-stream to 12-bit memory loader with optional read-back verify
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   start, base, len   load request: first address, word count (0 means 512)
//   rx_data/valid/ready  incoming byte stream, two bytes per word (high nibble first)
//   addr, wr, wdata    memory write port
//   rdata              memory read data (used only with verify)
//   busy, done, err    status: load active, end-of-load pulse, sticky verify mismatch
//   count              words written in the current or last load
//
// Build option: define MEM_LOADER_VERIFY_EN to read back and compare every word.
module mem_loader #(
    parameter int LEN_W = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [8:0]       base,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [8:0]       addr,
    output logic             wr,
    output logic [11:0]      wdata,
    input  logic [11:0]      rdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] count
);

`ifdef MEM_LOADER_VERIFY_EN
    typedef enum logic [2:0] {IDLE, HI, LO, WRITE, RD, CMP, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE} state_t;
`endif

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(512);

    state_t           state;
    logic [LEN_W-1:0] remaining;

`ifndef MEM_LOADER_VERIFY_EN
    logic unused_rdata;
    assign unused_rdata = ^rdata;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            remaining <= '0;
            addr      <= '0;
            wr        <= 1'b0;
            wdata     <= '0;
            rx_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
`ifdef MEM_LOADER_VERIFY_EN
            err       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base;
                        remaining <= (len == '0) ? FULL_LEN : len;
                        count     <= '0;
`ifdef MEM_LOADER_VERIFY_EN
                        err       <= 1'b0;
`endif
                        busy      <= 1'b1;
                        rx_ready  <= 1'b1;
                        state     <= HI;
                    end
                end
                HI: begin
                    // Upper nibble of the first byte is dropped.
                    if (rx_valid) begin
                        wdata[11:8] <= rx_data[3:0];
                        state       <= LO;
                    end
                end
                LO: begin
                    if (rx_valid) begin
                        wdata[7:0] <= rx_data;
                        rx_ready   <= 1'b0;
                        wr         <= 1'b1;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    wr    <= 1'b0;
                    count <= count + LEN_W'(1);
`ifdef MEM_LOADER_VERIFY_EN
                    state <= RD;
                end
                RD: begin
                    // Memory registers the read on this edge; data is valid in CMP.
                    state <= CMP;
                end
                CMP: begin
                    if (rdata != wdata) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            addr     <= addr + 9'd1;
                            rx_ready <= 1'b1;
                            state    <= HI;
                        end
                    end
                end
`else
                    remaining <= remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        // 9-bit add wraps 511 -> 0.
                        addr     <= addr + 9'd1;
                        rx_ready <= 1'b1;
                        state    <= HI;
                    end
                end
`endif
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    wr       <= 1'b0;
                    rx_ready <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - directed self-checking bench for mem_loader
module tb_mem_loader;
    localparam int LEN_W = 10;
`ifdef MEM_LOADER_VERIFY_EN
    localparam int WORD_CYC = 5;
`else
    localparam int WORD_CYC = 3;
`endif

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [8:0]       base = '0;
    logic [LEN_W-1:0] len = '0;
    logic [7:0]       rx_data = '0;
    logic             rx_valid = 1'b0;
    logic             rx_ready;
    logic [8:0]       addr;
    logic             wr;
    logic [11:0]      wdata;
    logic [11:0]      rdata = '0;
    logic             busy;
    logic             done;
    logic             err;
    logic [LEN_W-1:0] count;

    mem_loader #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base(base), .len(len),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .addr(addr), .wr(wr), .wdata(wdata), .rdata(rdata),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    // Synchronous memory model with optional corruption of address 3.
    logic [11:0] mem [0:511];
    logic        corrupt_en = 1'b0;
    always @(posedge clk) begin
        if (wr) mem[addr] <= wdata;
        rdata <= (corrupt_en && addr == 9'd3) ? (mem[addr] ^ 12'h001) : mem[addr];
    end

    // Monitor sampled on the falling edge.
    int cyc = 0;
    int done_cnt = 0;
    int ready_in_wr = 0;
    int log_addr[$];
    int log_data[$];
    int log_cyc[$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (wr) begin
            log_addr.push_back(int'(addr));
            log_data.push_back(int'(wdata));
            log_cyc.push_back(cyc);
        end
        if (done) done_cnt <= done_cnt + 1;
        if (wr && rx_ready) ready_in_wr <= ready_in_wr + 1;
    end

    int n_checks = 0;
    int n_pass = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_load(input logic [8:0] b, input logic [LEN_W-1:0] l);
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        base  = b;
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int i;
        rx_data  = b;
        rx_valid = 1'b1;
        i = 0;
        while (!rx_ready && i < 200) begin
            tick();
            i++;
        end
        if (!rx_ready) check("rx_ready_wait", rx_ready, 1);
        tick();
        if (gap > 0) begin
            rx_valid = 1'b0;
            rx_data  = 8'hAA;
            repeat (gap) tick();
        end
    endtask

    logic [7:0] bq[$];
    task automatic run_load(input logic [8:0] b, input logic [LEN_W-1:0] l,
                            input int gap, input string tag);
        int d0;
        int i;
        d0 = done_cnt;
        i = 0;
        start_load(b, l);
        foreach (bq[k]) send_byte(bq[k], gap);
        rx_valid = 1'b0;
        while (done_cnt == d0 && i < 3000) begin
            tick();
            i++;
        end
        repeat (3) tick();
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        int bad;
        int d;
        for (int i = 0; i < 512; i++) mem[i] = '0;

        // Reset state
        repeat (2) tick();
        check("rst_addr", addr, 0);
        check("rst_wr", wr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_count", count, 0);
        rstn = 1'b1;
        tick();

        // Basic two-word load with continuous bytes
        bq = '{8'h01, 8'h23, 8'h0F, 8'hFF};
        run_load(9'd0, 10'd2, 0, "basic");
        check("basic_nwr", log_addr.size(), 2);
        check("basic_a0", log_addr[0], 0);
        check("basic_d0", log_data[0], 12'h123);
        check("basic_a1", log_addr[1], 1);
        check("basic_d1", log_data[1], 12'hFFF);
        check("basic_spacing", log_cyc[1] - log_cyc[0], WORD_CYC);
        check("basic_count", count, 2);
        check("basic_hold_addr", addr, 1);
        check("basic_hold_wdata", wdata, 12'hFFF);
        check("basic_err", err, 0);

        // Address wrap at 511
        bq = '{8'h0A, 8'hBC, 8'h0D, 8'hEF};
        run_load(9'd511, 10'd2, 0, "wrap");
        check("wrap_nwr", log_addr.size(), 2);
        check("wrap_a0", log_addr[0], 511);
        check("wrap_d0", log_data[0], 12'hABC);
        check("wrap_a1", log_addr[1], 0);
        check("wrap_d1", log_data[1], 12'hDEF);

        // Gaps between bytes
        ready_in_wr = 0;
        bq = '{8'hA5, 8'h6C, 8'h30, 8'h01};
        run_load(9'd10, 10'd2, 2, "gap");
        check("gap_nwr", log_addr.size(), 2);
        check("gap_a0", log_addr[0], 10);
        check("gap_d0", log_data[0], 12'h56C);
        check("gap_a1", log_addr[1], 11);
        check("gap_d1", log_data[1], 12'h001);
        check("gap_ready_in_wr", ready_in_wr, 0);
        check("gap_count", count, 2);

        // Asynchronous reset mid-load, after the high byte of word 1
        d = done_cnt;
        start_load(9'd20, 10'd3);
        send_byte(8'h07, 0);
        rx_valid = 1'b0;
        check("mid_busy_before", busy, 1);
        #1 rstn = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_addr", addr, 0);
        check("arst_wdata", wdata, 0);
        check("arst_rx_ready", rx_ready, 0);
        check("arst_count", count, 0);
        check("arst_wr", wr, 0);
        tick();
        rstn = 1'b1;
        tick();
        check("arst_no_done", done_cnt - d, 0);
        bq = '{8'h0B, 8'hCD};
        run_load(9'd5, 10'd1, 0, "post_rst");
        check("post_rst_nwr", log_addr.size(), 1);
        check("post_rst_a0", log_addr[0], 5);
        check("post_rst_d0", log_data[0], 12'hBCD);
        check("post_rst_count", count, 1);

        // len = 0 loads 512 words and wraps back to base
        bq.delete();
        for (int i = 0; i < 512; i++) begin
            d = (i * 37 + 5) & 12'hFFF;
            bq.push_back(8'((d >> 8) & 4'hF | 8'h50));
            bq.push_back(8'(d & 8'hFF));
        end
        run_load(9'd100, 10'd0, 0, "full");
        check("full_nwr", log_addr.size(), 512);
        check("full_first_addr", log_addr[0], 100);
        check("full_last_addr", log_addr[511], 99);
        check("full_count", count, 512);
        bad = 0;
        for (int i = 0; i < 512 && i < log_addr.size(); i++) begin
            if (log_addr[i] != ((100 + i) % 512) || log_data[i] != ((i * 37 + 5) & 12'hFFF))
                bad++;
        end
        check("full_word_errors", bad, 0);

`ifdef MEM_LOADER_VERIFY_EN
        // Read-back mismatch at address 3 stops the load
        corrupt_en = 1'b1;
        bq = '{8'h01, 8'h11, 8'h02, 8'h22};
        run_load(9'd2, 10'd4, 0, "vfy");
        check("vfy_err", err, 1);
        check("vfy_count", count, 2);
        check("vfy_nwr", log_addr.size(), 2);
        check("vfy_a1", log_addr[1], 3);
        corrupt_en = 1'b0;
`else
        check("no_vfy_err", err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
